// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand widths and the CDB requester map.
package cpu_pkg;

  localparam int VREG_W      = 5;
  localparam int DATA_W      = 32;
  localparam int CDB_NUM_REQ = 3;

  typedef enum logic [1:0] {
    CDB_ALU = 2'd0,
    CDB_LSU = 2'd1,
    CDB_BRU = 2'd2
  } cdb_src_e;

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NUM_REQ.
module cdb_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [SRC_W-1:0]   grant_idx,
  output logic               any_grant
);

  // Scan from the farthest offset down so the nearest request overwrites the result.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = SRC_W'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per writeback requester, round-robin grant,
// registered broadcast to reservation stations and ROB.
module cdb_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int VREG_W  = cpu_pkg::VREG_W,
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hci_rdy,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*VREG_W-1:0] req_vregid,
  input  logic [NUM_REQ*DATA_W-1:0] req_val,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_en,
  output logic [VREG_W-1:0]         cdb_vregid,
  output logic [DATA_W-1:0]         cdb_val,
  output logic [SRC_W-1:0]          cdb_src
);

  logic [NUM_REQ-1:0] hold_valid;
  logic [VREG_W-1:0]  hold_vregid [NUM_REQ];
  logic [DATA_W-1:0]  hold_val    [NUM_REQ];
  logic [VREG_W-1:0]  in_vregid   [NUM_REQ];
  logic [DATA_W-1:0]  in_val      [NUM_REQ];
  logic [SRC_W-1:0]   rr_ptr;

  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               any_grant;
  logic [NUM_REQ-1:0] accept;
  logic               active;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign in_vregid[gi] = req_vregid[gi*VREG_W +: VREG_W];
      assign in_val[gi]    = req_val[gi*DATA_W +: DATA_W];
    end
  endgenerate

  cdb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req       (hold_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A slot being drained this cycle can be refilled on the same edge.
  assign active    = hci_rdy & ~flush;
  assign req_ready = {NUM_REQ{active}} & (~hold_valid | grant);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        hold_vregid[i] <= in_vregid[i];
        hold_val[i]    <= in_val[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= '0;
      rr_ptr     <= '0;
      cdb_en     <= 1'b0;
      cdb_vregid <= '0;
      cdb_val    <= '0;
      cdb_src    <= '0;
    end else if (hci_rdy) begin
      if (flush) begin
        hold_valid <= '0;
        cdb_en     <= 1'b0;
      end else begin
        hold_valid <= (hold_valid & ~grant) | accept;
        cdb_en     <= any_grant;
        if (any_grant) begin
          cdb_vregid <= hold_vregid[grant_idx];
          cdb_val    <= hold_val[grant_idx];
          cdb_src    <= grant_idx;
          rr_ptr     <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a slot/pointer reference model predicts every broadcast.
module tb_cdb_arbiter;
  localparam int N  = 3;
  localparam int VW = 5;
  localparam int DW = 32;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            hci_rdy = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*VW-1:0] req_vregid = '0;
  logic [N*DW-1:0] req_val = '0;
  logic [N-1:0]    req_ready;
  logic            cdb_en;
  logic [VW-1:0]   cdb_vregid;
  logic [DW-1:0]   cdb_val;
  logic [SW-1:0]   cdb_src;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .hci_rdy(hci_rdy), .flush(flush),
    .req_valid(req_valid), .req_vregid(req_vregid), .req_val(req_val),
    .req_ready(req_ready), .cdb_en(cdb_en), .cdb_vregid(cdb_vregid),
    .cdb_val(cdb_val), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] vreg;
    logic [DW-1:0] val;
    int            src;
  } bcast_t;

  bcast_t sb[$];
  int checks = 0;
  int failures = 0;
  int nbcast = 0;

  // Reference model state: which requesters have an un-broadcast writeback, and whose turn it is.
  bit            m_hold [N];
  logic [VW-1:0] m_hvreg [N];
  logic [DW-1:0] m_hval [N];
  int            m_rr = 0;
  bit            m_en = 0;
  logic [VW-1:0] m_vreg = '0;
  logic [DW-1:0] m_val = '0;
  int            m_src = 0;
  bit [N-1:0]    m_acc = '0;
  bit            edge_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model evaluation just before each rising edge, once inputs are settled.
  initial begin
    for (int i = 0; i < N; i++) begin m_hold[i] = 0; m_hvreg[i] = '0; m_hval[i] = '0; end
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        for (int i = 0; i < N; i++) m_hold[i] = 0;
        m_rr = 0; m_en = 0; m_vreg = '0; m_val = '0; m_src = 0;
        m_acc = '0; edge_en = 0;
        sb.delete();
      end else if (!hci_rdy) begin
        m_acc = '0; edge_en = 0;
        check("ready_stall", req_ready, '0);
      end else if (flush) begin
        m_acc = '0; edge_en = 1;
        check("ready_flush", req_ready, '0);
        for (int i = 0; i < N; i++) m_hold[i] = 0;
        m_en = 0;
      end else begin
        int g;
        bit [N-1:0] rdy;
        g = -1;
        for (int off = 0; off < N; off++)
          if (g < 0 && m_hold[(m_rr + off) % N]) g = (m_rr + off) % N;
        for (int i = 0; i < N; i++) rdy[i] = !m_hold[i] || (g == i);
        check("ready", req_ready, rdy);
        m_acc = req_valid & rdy;
        if (g >= 0) begin
          bcast_t b;
          b.vreg = m_hvreg[g]; b.val = m_hval[g]; b.src = g;
          sb.push_back(b);
          m_en = 1; m_vreg = b.vreg; m_val = b.val; m_src = g;
          m_rr = (g + 1) % N;
          m_hold[g] = 0;
        end else begin
          m_en = 0;
        end
        for (int i = 0; i < N; i++) begin
          if (m_acc[i]) begin
            m_hold[i]  = 1;
            m_hvreg[i] = req_vregid[i*VW +: VW];
            m_hval[i]  = req_val[i*DW +: DW];
          end
        end
        edge_en = 1;
      end
    end
  end

  // Monitor: pop one expectation per broadcast the DUT presents; stalled edges must freeze outputs.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (edge_en) begin
        if (cdb_en) begin
          if (sb.size() == 0) begin
            failures++; checks++;
            $display("FAIL spurious_bcast: got vregid=%0h src=%0d expected none at %0t",
                     cdb_vregid, cdb_src, $time);
          end else begin
            bcast_t b;
            b = sb.pop_front();
            nbcast++;
            $display("bcast %0d: src=%0d vregid=%0h val=%08h", nbcast, cdb_src, cdb_vregid, cdb_val);
            check("bcast_src", cdb_src, b.src);
            check("bcast_vregid", cdb_vregid, b.vreg);
            check("bcast_val", cdb_val, b.val);
          end
        end else begin
          check("missed_bcast", sb.size(), 0);
          sb.delete();
        end
      end else begin
        check("frozen_en", cdb_en, m_en);
        check("frozen_vregid", cdb_vregid, m_vreg);
        check("frozen_val", cdb_val, m_val);
        check("frozen_src", cdb_src, m_src);
      end
    end
  end

  // Drive one cycle; a requester keeps its data until the model saw it accepted.
  task automatic step(input logic [N-1:0] mask, input bit hci, input bit fl);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && !m_acc[i]) begin
        // still waiting for acceptance: hold stable
      end else if (mask[i]) begin
        req_valid[i] = 1'b1;
        req_vregid[i*VW +: VW] = VW'($urandom);
        req_val[i*DW +: DW] = $urandom;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    hci_rdy = hci;
    flush = fl;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ready", req_ready, 3'b111);

    step(3'b111, 1, 0);
    repeat (5) step(3'b000, 1, 0);

    step(3'b001, 1, 0);
    req_vregid[VW-1:0] = 5'd5;
    req_val[DW-1:0] = 32'hDEADBEEF;
    repeat (4) step(3'b000, 1, 0);

    repeat (8) step(3'b010, 1, 0);
    repeat (8) step(3'b101, 1, 0);
    repeat (3) step(3'b000, 1, 0);

    step(3'b110, 1, 0);
    repeat (3) step(3'b000, 0, 0);
    repeat (4) step(3'b000, 1, 0);

    step(3'b101, 1, 0);
    step(3'b000, 1, 1);
    repeat (3) step(3'b000, 1, 0);

    step(3'b011, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    #1;
    check("rst_cdb_en", cdb_en, 0);
    check("rst_cdb_vregid", cdb_vregid, 0);
    check("rst_cdb_val", cdb_val, 0);
    check("rst_cdb_src", cdb_src, 0);
    step(3'b000, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_ready", req_ready, 3'b111);

    for (int c = 0; c < 400; c++)
      step(N'($urandom), ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 5));

    repeat (10) step(3'b000, 1, 0);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
